// File: rtl/bounce_gen_if.sv
// Signal bundle between a clean-level source and the bounce_gen emulator.
// The statistics port pair exists only when BOUNCE_GEN_STATS_EN is defined.
interface bounce_gen_if;
   logic        enable_i;
   logic        clean_sig_i;
   logic        raw_sig_o;
   logic        busy_o;
`ifdef BOUNCE_GEN_STATS_EN
   logic        clr_stats_i;
   logic [15:0] glitch_cnt_o;

   modport master (
      output enable_i, clean_sig_i, clr_stats_i,
      input  raw_sig_o, busy_o, glitch_cnt_o
   );
   modport slave (
      input  enable_i, clean_sig_i, clr_stats_i,
      output raw_sig_o, busy_o, glitch_cnt_o
   );
`else
   modport master (
      output enable_i, clean_sig_i,
      input  raw_sig_o, busy_o
   );
   modport slave (
      input  enable_i, clean_sig_i,
      output raw_sig_o, busy_o
   );
`endif
endinterface

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: after each clean level change the raw output chatters from an LFSR
// for BOUNCE_CYCLES cycles, then settles. Define BOUNCE_GEN_STATS_EN to add a glitch counter.
module bounce_gen #(
   parameter int unsigned BOUNCE_CYCLES = 8,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   bounce_gen_if.slave  bus
);

   localparam int unsigned CNT_W    = $clog2(BOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

   typedef enum logic {
      IDLE   = 1'b0,
      BOUNCE = 1'b1
   } state_e;

   state_e           state_q,  state_d;
   logic             raw_q,    raw_d;
   logic             busy_q,   busy_d;
   logic             stable_q, stable_d;
   logic             target_q, target_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [7:0]       lfsr_q,   lfsr_d;
   logic [7:0]       lfsr_step;

   assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!bus.enable_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.clean_sig_i != stable_q) state_d = BOUNCE;
            BOUNCE:  if (cnt_q == '0)                 state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      raw_d    = raw_q;
      busy_d   = busy_q;
      stable_d = stable_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      if (!bus.enable_i) begin
         // Bypass also aborts any bounce in progress; the LFSR is frozen.
         raw_d    = bus.clean_sig_i;
         stable_d = bus.clean_sig_i;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.clean_sig_i != stable_q) begin
                  target_d = bus.clean_sig_i;
                  cnt_d    = CNT_LOAD;
                  raw_d    = ~raw_q;
                  busy_d   = 1'b1;
               end else begin
                  raw_d    = stable_q;
                  busy_d   = 1'b0;
               end
            end
            BOUNCE: begin
               lfsr_d = lfsr_step;
               if (cnt_q != '0) begin
                  raw_d = raw_q ^ lfsr_q[0];
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  raw_d    = target_q;
                  stable_d = target_q;
                  busy_d   = 1'b0;
               end
            end
            default: begin
               busy_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         raw_q    <= 1'b0;
         busy_q   <= 1'b0;
         stable_q <= 1'b0;
         target_q <= 1'b0;
         cnt_q    <= '0;
         lfsr_q   <= SEED_EFF;
      end else begin
         raw_q    <= raw_d;
         busy_q   <= busy_d;
         stable_q <= stable_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         lfsr_q   <= lfsr_d;
      end
   end

   assign bus.raw_sig_o = raw_q;
   assign bus.busy_o    = busy_q;

`ifdef BOUNCE_GEN_STATS_EN
   logic [15:0] glitch_q, glitch_d;
   logic        toggle;

   // Only toggles produced by the emulator count; bypass-following edges do not.
   always_comb begin
      toggle = 1'b0;
      if (bus.enable_i && (state_q == BOUNCE || bus.clean_sig_i != stable_q)) begin
         toggle = (raw_d != raw_q);
      end
      glitch_d = glitch_q;
      if (bus.clr_stats_i) begin
         glitch_d = 16'h0000;
      end else if (toggle && glitch_q != 16'hFFFF) begin
         glitch_d = glitch_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         glitch_q <= 16'h0000;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign bus.glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Directed testbench for bounce_gen (BOUNCE_CYCLES=4, seed 8'hA5); stats checks only
// when BOUNCE_GEN_STATS_EN is defined.
module tb_bounce_gen;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   bounce_gen_if bus();

   bounce_gen #(
      .BOUNCE_CYCLES (4),
      .LFSR_SEED     (8'hA5)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      bus.enable_i    = 1'b1;
      bus.clean_sig_i = 1'b0;
`ifdef BOUNCE_GEN_STATS_EN
      bus.clr_stats_i = 1'b0;
`endif
      rst_ni = 1'b0;
      #12;
      tests_run++;
      if (bus.raw_sig_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_raw: got %b expected 0", bus.raw_sig_o);
      end
      tests_run++;
      if (bus.busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
      end
`ifdef BOUNCE_GEN_STATS_EN
      tests_run++;
      if (bus.glitch_cnt_o !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_glitch: got %h expected 0000", bus.glitch_cnt_o);
      end
`endif
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (bus.raw_sig_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset[%0d]: got raw=%b busy=%b expected raw=0 busy=0",
                     i, bus.raw_sig_o, bus.busy_o);
         end
      end
   endtask

   // Seed A5: LFSR bit0 sequence 1,0,1,0 -> raw 1,0,0,1 then settle at 1.
   task automatic test_bounce();
      logic [4:0] exp_raw;
      logic [4:0] exp_busy;
      exp_raw  = 5'b11001;   // index 0 = N+1
      exp_busy = 5'b01111;
      bus.clean_sig_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (bus.raw_sig_o !== exp_raw[i] || bus.busy_o !== exp_busy[i]) begin
            tests_failed++;
            $display("FAIL bounce[N+%0d]: got raw=%b busy=%b expected raw=%b busy=%b",
                     i + 1, bus.raw_sig_o, bus.busy_o, exp_raw[i], exp_busy[i]);
         end
      end
      step();
      tests_run++;
      if (bus.raw_sig_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL bounce_settled: got raw=%b busy=%b expected raw=1 busy=0",
                  bus.raw_sig_o, bus.busy_o);
      end
`ifdef BOUNCE_GEN_STATS_EN
      tests_run++;
      if (bus.glitch_cnt_o !== 16'd3) begin
         tests_failed++;
         $display("FAIL bounce_glitch_cnt: got %0d expected 3", bus.glitch_cnt_o);
      end
`endif
   endtask

   task automatic test_bypass();
      logic c;
      bus.enable_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         c = (i % 2 == 1);
         bus.clean_sig_i = c;
         step();
         tests_run++;
         if (bus.raw_sig_o !== c || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass[%0d]: got raw=%b busy=%b expected raw=%b busy=0",
                     i, bus.raw_sig_o, bus.busy_o, c);
         end
      end
`ifdef BOUNCE_GEN_STATS_EN
      tests_run++;
      if (bus.glitch_cnt_o !== 16'd3) begin
         tests_failed++;
         $display("FAIL bypass_glitch_cnt: got %0d expected 3", bus.glitch_cnt_o);
      end
`endif
   endtask

   task automatic test_enable_no_bounce();
      bus.enable_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (bus.raw_sig_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_rise[%0d]: got raw=%b busy=%b expected raw=0 busy=0",
                     i, bus.raw_sig_o, bus.busy_o);
         end
      end
   endtask

   task automatic test_mid_bounce();
      logic exp_busy;
      bus.clean_sig_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 2) bus.clean_sig_i = 1'b0;
         exp_busy = (k != 5 && k != 10);
         tests_run++;
         if (bus.busy_o !== exp_busy) begin
            tests_failed++;
            $display("FAIL mid_busy[N+%0d]: got %b expected %b", k, bus.busy_o, exp_busy);
         end
         if (k == 1 || k == 5 || k == 6 || k == 10) begin
            tests_run++;
            if (bus.raw_sig_o !== (k <= 5)) begin
               tests_failed++;
               $display("FAIL mid_raw[N+%0d]: got %b expected %b", k, bus.raw_sig_o, (k <= 5));
            end
         end
      end
   endtask

   task automatic test_abort();
      bus.clean_sig_i = 1'b1;
      step();
      step();
      tests_run++;
      if (bus.busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_pre_busy: got %b expected 1", bus.busy_o);
      end
      bus.enable_i = 1'b0;
      step();
      tests_run++;
      if (bus.busy_o !== 1'b0 || bus.raw_sig_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort: got raw=%b busy=%b expected raw=1 busy=0",
                  bus.raw_sig_o, bus.busy_o);
      end
      bus.enable_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (bus.busy_o !== 1'b0 || bus.raw_sig_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_reenable[%0d]: got raw=%b busy=%b expected raw=1 busy=0",
                     i, bus.raw_sig_o, bus.busy_o);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.clean_sig_i = 1'b0;
      step();
      step();
      tests_run++;
      if (bus.busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_pre_busy: got %b expected 1", bus.busy_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if (bus.raw_sig_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: got raw=%b busy=%b expected raw=0 busy=0",
                  bus.raw_sig_o, bus.busy_o);
      end
`ifdef BOUNCE_GEN_STATS_EN
      tests_run++;
      if (bus.glitch_cnt_o !== 16'h0000) begin
         tests_failed++;
         $display("FAIL async_glitch: got %h expected 0000", bus.glitch_cnt_o);
      end
`endif
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step();
      tests_run++;
      if (bus.raw_sig_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_release: got raw=%b busy=%b expected raw=0 busy=0",
                  bus.raw_sig_o, bus.busy_o);
      end
   endtask

`ifdef BOUNCE_GEN_STATS_EN
   task automatic test_stats();
      force dut.glitch_q = 16'hFFFE;
      #1;
      release dut.glitch_q;
      bus.clean_sig_i = 1'b1;
      for (int i = 0; i < 5; i++) step();
      tests_run++;
      if (bus.glitch_cnt_o !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL stats_saturate: got %h expected ffff", bus.glitch_cnt_o);
      end
      bus.clean_sig_i = 1'b0;
      bus.clr_stats_i = 1'b1;
      step();
      tests_run++;
      if (bus.glitch_cnt_o !== 16'h0000 || bus.raw_sig_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL stats_clr_priority: got cnt=%h raw=%b expected cnt=0000 raw=0",
                  bus.glitch_cnt_o, bus.raw_sig_o);
      end
      bus.clr_stats_i = 1'b0;
      for (int i = 0; i < 4; i++) step();
   endtask
`endif

   initial begin
`ifdef BOUNCE_GEN_STATS_EN
      bus.clr_stats_i = 1'b0;
`endif
      test_reset();
      test_bounce();
      test_bypass();
      test_enable_no_bounce();
      test_mid_bounce();
      test_abort();
      test_async_reset();
`ifdef BOUNCE_GEN_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
